debounce_scan_ctrl: RTL and testbench
=====================================

Name: debounce_scan_ctrl

Overview:
- Time-multiplexed debounce controller that serves N_CH switch inputs from one shared sample-tick divider and one shared compare/count engine.
- On each sample tick, a scan sequencer visits the channels in order, one per clock, and updates that channel's stable-count and debounced level.
- Sits between raw board switches/buttons and user logic. Replaces per-switch FSM debouncers and per-switch 10 ms counters.

Parameters:
- N_CH, 4, number of switch channels (2..16).
- TICK_DIV, 1_000_000, clk cycles per sample tick (10 ms at 100 MHz). Must be >= N_CH+2.
- STABLE_TICKS, 3, consecutive ticks a new level must persist before db changes (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  scan enable. 0 freezes divider and sequencer; db holds.
- sw  in  N_CH  raw asynchronous switch inputs.
- db  out  N_CH  debounced levels.
- rise  out  N_CH  one-clk pulse when db[i] goes 0->1.
- fall  out  N_CH  one-clk pulse when db[i] goes 1->0.
- tick  out  1  one-clk pulse, the shared sample tick.
- busy  out  1  high while the sequencer is in SCAN.
- overrun  out  1  sticky; set if a tick arrives while busy.

Behaviour:
- Reset (reset==0 at clk edge):
  - db, rise, fall, tick, busy and overrun = 0.
  - Divider = 0, all channel counts = 0, scan index = 0, state = IDLE.
  - Sync flops = 0.
  - Reset asserted mid-scan aborts the scan immediately; there is no partial update after reset.
- Synchronizer: each sw[i] passes through 2 flip-flops to give s[i]. The sync flops run even when en=0.
- Divider:
  - Counts 0..TICK_DIV-1 while en=1, then wraps.
  - tick=1 on the cycle the divider equals TICK_DIV-1.
  - en=0 holds the divider value.
- Sequencer FSM, states IDLE and SCAN:
  - IDLE: tick=1 -> SCAN with idx=0. Otherwise stay in IDLE.
  - SCAN: process channel idx this cycle. If idx==N_CH-1 -> IDLE with idx=0. Otherwise idx++.
  - en=0 in SCAN: hold state and idx. No channel is processed that cycle.
  - busy = (state==SCAN).
  - If tick=1 while in SCAN, set overrun=1 and drop the tick (no restart, no queueing). overrun clears only on reset.
- Channel processing (SCAN, en=1, channel i=idx):
  - If s[i]==db[i]: cnt[i] <= 0.
  - Else if cnt[i]==STABLE_TICKS-1: db[i] <= s[i], cnt[i] <= 0, and pulse rise[i] or fall[i] according to the new level.
  - Else: cnt[i] <= cnt[i]+1.
  - cnt width = clog2(STABLE_TICKS+1), minimum 1. cnt never exceeds STABLE_TICKS-1.
- Timing:
  - Tick in cycle T puts the FSM in SCAN at T+1.
  - Channel i is processed in cycle T+1+i.
  - A db/rise/fall change for channel i is visible in cycle T+2+i.
  - rise/fall pulses are exactly 1 cycle wide. At most one channel changes per cycle.
- Edge cases:
  - A glitch shorter than one tick interval, seen at a single sample, resets the count on the next agreeing sample. db does not change.
  - A level that alternates across ticks never changes db.
  - STABLE_TICKS=1: db follows s at the first sample that differs.
  - Channels that are not being processed keep cnt and db unchanged.

Test Plan (TICK_DIV=8, N_CH=4, STABLE_TICKS=3):
- Reset with sw=4'b1111: all outputs 0 during reset. After release, the first tick appears 8 cycles later. db=4'b1111 after the 3rd tick, with db[0] set 2 cycles after the 3rd tick and db[3] 5 cycles after it. rise[0..3] each pulse once in consecutive cycles.
- sw[2] held at 1 for 2 ticks then back to 0 -> db[2] stays 0, no rise pulse, cnt[2] returns to 0.
- db=4'b0001, then sw[0] driven 0 -> fall[0] pulses 1 cycle, 2 cycles after the 3rd tick seen at 0. No other rise/fall bits toggle.
- en=0 asserted on the cycle the FSM is at idx=1 for 5 cycles -> busy stays 1, idx holds, the divider freezes, and tick does not pulse. Scan resumes at idx=1 when en returns to 1.
- Rerun with TICK_DIV=4 (< N_CH+2) -> overrun=1 after the first tick collides with SCAN and stays 1 until reset drops low. Reset mid-scan -> busy=0 the following cycle.
- sw[1] toggled every tick for 10 ticks -> db[1] constant 0, and neither rise[1] nor fall[1] pulses.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_scan_ctrl
//  Description : Time-multiplexed switch debouncer. One shared sample-tick
//                divider and one shared compare/count engine serve N_CH
//                channels; on every tick a sequencer visits the channels one
//                per clock and updates each channel's stable count and level.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_scan_ctrl #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 1_000_000,
    parameter int STABLE_TICKS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick,
    output logic            busy,
    output logic            overrun
);

    localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_idx_w = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_cnt_w = ($clog2(STABLE_TICKS + 1) > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(TICK_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_CH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_TICKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    logic [N_CH-1:0]    r_sync1;
    logic [N_CH-1:0]    r_sync2;
    logic [c_div_w-1:0] r_div;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic               w_proc;
    logic               w_tick;
    logic [c_cnt_w-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]    r_db;
    logic [N_CH-1:0]    r_rise;
    logic [N_CH-1:0]    r_fall;
    logic               r_overrun;

    // Tick is qualified by reset so nothing pulses while reset is held.
    assign w_tick  = reset & en & (r_div == c_div_max);
    assign tick    = w_tick;
    assign busy    = (r_state == ST_SCAN);
    assign db      = r_db;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign overrun = r_overrun;

    // Two-flop synchronizer; keeps running regardless of en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared sample-tick divider, frozen while en is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == c_div_max) ? '0 : r_div + 1'b1;
        end
    end

    // Sequencer state and scan index register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Sequencer next-state: start a scan on tick, walk channels one per clock.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_proc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (en) begin
                    w_proc = 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Sticky overrun: a tick landing mid-scan is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state == ST_SCAN)) begin
            r_overrun <= 1'b1;
        end
    end

    // Shared compare/count engine applied to the channel selected by r_idx.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (w_proc) begin
                if (r_sync2[r_idx] == r_db[r_idx]) begin
                    r_cnt[r_idx] <= '0;
                end else if (r_cnt[r_idx] == c_cnt_max) begin
                    r_db[r_idx]  <= r_sync2[r_idx];
                    r_cnt[r_idx] <= '0;
                    if (r_sync2[r_idx]) begin
                        r_rise[r_idx] <= 1'b1;
                    end else begin
                        r_fall[r_idx] <= 1'b1;
                    end
                end else begin
                    r_cnt[r_idx] <= r_cnt[r_idx] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_scan_ctrl
//  Description : Self-checking bench for debounce_scan_ctrl. A behavioural
//                model tracks sample ticks, scan position and per-channel
//                run lengths; a second instance with a short divider covers
//                the overrun and mid-scan reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [3:0] sw, db, rise, fall;
    logic       tick, busy, overrun;

    logic       reset4, en4;
    logic [3:0] sw4, db4, rise4, fall4;
    logic       tick4, busy4, ovr4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sw(sw), .db(db), .rise(rise),
        .fall(fall), .tick(tick), .busy(busy), .overrun(overrun)
    );

    debounce_scan_ctrl #(.N_CH(N), .TICK_DIV(4), .STABLE_TICKS(ST)) u_dut4 (
        .clk(clk), .reset(reset4), .en(en4), .sw(sw4), .db(db4), .rise(rise4),
        .fall(fall4), .tick(tick4), .busy(busy4), .overrun(ovr4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: ticks come every TD enabled cycles; a scan visits one
    // channel per enabled cycle; a channel accepts a new level after ST
    // consecutive differing samples.
    logic [3:0] m_s1, m_s2, m_db, m_rise, m_fall;
    int         m_run [4];
    int         m_phase = 0;
    int         m_pos   = -1;
    bit         m_ovr   = 1'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model_upd
        bit tk;
        int ch;
        m_valid = 1'b1;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
            m_phase = 0; m_pos = -1; m_ovr = 1'b0;
            foreach (m_run[i]) m_run[i] = 0;
        end else begin
            tk = en && (m_phase == TD - 1);
            ch = m_pos;
            m_rise = '0;
            m_fall = '0;
            if (tk && ch >= 0) m_ovr = 1'b1;
            if (ch >= 0 && en) begin
                if (m_s2[ch] == m_db[ch]) begin
                    m_run[ch] = 0;
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == ST) begin
                        m_db[ch]  = m_s2[ch];
                        m_run[ch] = 0;
                        if (m_s2[ch]) m_rise[ch] = 1'b1;
                        else          m_fall[ch] = 1'b1;
                    end
                end
                m_pos = (ch == N - 1) ? -1 : ch + 1;
            end else if (ch < 0 && tk) begin
                m_pos = 0;
            end
            if (en) m_phase = (m_phase + 1) % TD;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("db",      32'(db),      32'(m_db));
            check("rise",    32'(rise),    32'(m_rise));
            check("fall",    32'(fall),    32'(m_fall));
            check("tick",    32'(tick),    32'(reset && en && (m_phase == TD - 1)));
            check("busy",    32'(busy),    32'(m_pos >= 0));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    initial begin : stim
        int  n_r2, n_f0, n_other, n_e1;
        bit  found;
        reset = 1'b0; en = 1'b1; sw = 4'b1111;
        reset4 = 1'b0; en4 = 1'b1; sw4 = 4'b0000;

        // Reset state
        step(); step(); step();
        check("rst_db",   32'(db), 32'(0));
        check("rst_rise", 32'(rise), 32'(0));
        check("rst_fall", 32'(fall), 32'(0));
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovr",  32'(overrun), 32'(0));
        reset = 1'b1;

        // Power-up with all switches high: ticks at 7,15,23; channels land 25..28
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 6)  check("lit_tick6", 32'(tick), 32'(0));
            if (n == 7)  check("lit_tick7", 32'(tick), 32'(1));
            if (n == 8)  check("lit_busy8", 32'(busy), 32'(1));
            if (n == 24) check("lit_db24",  32'(db), 32'(4'b0000));
            if (n == 25) begin
                check("lit_db25",   32'(db), 32'(4'b0001));
                check("lit_rise25", 32'(rise), 32'(4'b0001));
            end
            if (n == 28) begin
                check("lit_db28",   32'(db), 32'(4'b1111));
                check("lit_rise28", 32'(rise), 32'(4'b1000));
            end
            if (n == 29) check("lit_rise29", 32'(rise), 32'(0));
        end

        // Settle to db=0001
        sw = 4'b0001;
        repeat (40) step();
        check("lit_db_0001", 32'(db), 32'(4'b0001));

        // Short excursions on sw[2] (2 samples each) never reach db
        n_r2 = 0;
        sw = 4'b0101; for (int k = 0; k < 16; k++) begin step(); n_r2 += int'(rise[2]); end
        sw = 4'b0001; for (int k = 0; k < 32; k++) begin step(); n_r2 += int'(rise[2]); end
        sw = 4'b0101; for (int k = 0; k < 16; k++) begin step(); n_r2 += int'(rise[2]); end
        sw = 4'b0001; for (int k = 0; k < 24; k++) begin step(); n_r2 += int'(rise[2]); end
        check("glitch_db",    32'(db), 32'(4'b0001));
        check("glitch_rise2", 32'(n_r2), 32'(0));

        // Release sw[0]: exactly one fall[0], nothing else
        n_f0 = 0; n_other = 0;
        sw = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            step();
            n_f0    += int'(fall[0]);
            n_other += $countones(rise) + $countones(fall[3:1]);
        end
        check("fall0_count", 32'(n_f0), 32'(1));
        check("other_edges", 32'(n_other), 32'(0));
        check("lit_db_0000", 32'(db), 32'(4'b0000));

        // Pause scanning at idx=1 for five cycles
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (tick === 1'b1) found = 1'b1;
        end
        check("en_tick_found", 32'(found), 32'(1));
        step();                                   // T+1: channel 0
        step();                                   // T+2: at channel 1
        check("en_busy_t2", 32'(busy), 32'(1));
        en = 1'b0;
        for (int k = 3; k <= 13; k++) begin
            step();
            if (k <= 7) begin
                check("en_busy_hold", 32'(busy), 32'(1));
                check("en_tick_hold", 32'(tick), 32'(0));
            end
            if (k == 7)  en = 1'b1;
            if (k == 9)  check("en_busy_t9", 32'(busy), 32'(1));
            if (k == 10) check("en_busy_t10", 32'(busy), 32'(0));
            if (k == 12) check("en_tick_t12", 32'(tick), 32'(0));
            if (k == 13) check("en_tick_t13", 32'(tick), 32'(1));
        end

        // Toggle sw[1] every tick interval for 10 ticks
        n_e1 = 0;
        for (int t = 0; t < 10; t++) begin
            sw[1] = ~sw[1];
            for (int k = 0; k < TD; k++) begin
                step();
                n_e1 += int'(rise[1]) + int'(fall[1]);
            end
        end
        sw = 4'b0000;
        repeat (12) step();
        check("toggle_db1",    32'(db[1]), 32'(0));
        check("toggle_edges1", 32'(n_e1), 32'(0));

        // Short divider: ticks at 3,7,11; tick at 7 collides with the scan
        reset4 = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (n == 3)  begin check("d4_tick3", 32'(tick4), 32'(1)); check("d4_busy3", 32'(busy4), 32'(0)); end
            if (n == 4)  check("d4_busy4", 32'(busy4), 32'(1));
            if (n == 7)  begin
                check("d4_tick7", 32'(tick4), 32'(1));
                check("d4_busy7", 32'(busy4), 32'(1));
                check("d4_ovr7",  32'(ovr4), 32'(0));
            end
            if (n == 8)  begin check("d4_ovr8", 32'(ovr4), 32'(1)); check("d4_busy8", 32'(busy4), 32'(0)); end
            if (n == 10) check("d4_ovr10", 32'(ovr4), 32'(1));
            if (n == 12) begin check("d4_busy12", 32'(busy4), 32'(1)); check("d4_ovr12", 32'(ovr4), 32'(1)); end
            if (n == 13) begin check("d4_busy13", 32'(busy4), 32'(1)); reset4 = 1'b0; end
            if (n == 14) begin
                check("d4_rst_busy", 32'(busy4), 32'(0));
                check("d4_rst_ovr",  32'(ovr4), 32'(0));
                check("d4_rst_db",   32'(db4), 32'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
